barrel_shift_pipe: RTL
======================

Name: barrel_shift_pipe

Overview:
- Parametrised, pipelined successor to the team's 4-bit combinational rotator.
- Performs rotate-right, rotate-left, logical-right and arithmetic-right shift on a WIDTH-bit word.
- Built as a log2(WIDTH)-stage registered mux tree with valid/ready handshakes on both sides.
- Sits between an operand source and the ALU result path; a user tag travels with each operation for out-of-band tracking.

Parameters:
- WIDTH, 32, data width; power of two, >= 4.
- SHW, $clog2(WIDTH), shift-amount width and pipeline stage count; derived, not overridden.
- TAG_W, 4, width of the pass-through tag.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operation offered.
- in_ready  output  1  block accepts the operation this cycle.
- in_data  input  WIDTH  operand.
- in_amt  input  SHW  shift/rotate amount, 0..WIDTH-1.
- in_op  input  2  operation: 0=ROR, 1=ROL, 2=SRL, 3=SRA.
- in_tag  input  TAG_W  user tag.
- out_valid  output  1  result available.
- out_ready  input  1  downstream accepts the result.
- out_data  output  WIDTH  result.
- out_tag  output  TAG_W  tag of the result.

Behaviour:
- Reset (async assert, sync release):
  - all stage valid bits, out_valid, out_data and out_tag clear to 0.
  - in_ready reads 1 one cycle after release.
- Function, with n = in_amt and i the bit index:
  - ROR: out[i] = in[(i+n) mod WIDTH].
  - ROL: out[i] = in[(i-n) mod WIDTH].
  - SRL: zero fill from the MSB side.
  - SRA: every vacated bit takes the original in_data[WIDTH-1].
  - n=0 passes data unchanged for every op.
- Stage k (k = 0..SHW-1):
  - applies a shift of 2^k when amt[k]=1, else passes the word through.
  - registers word, remaining amt bits, op, tag, sign bit and valid.
  - Stage 0 takes in_data combinationally; the stage SHW-1 register drives the outputs.
- Latency: exactly SHW cycles from the accept edge to out_valid=1 when there is no backpressure. Throughput: 1 op per cycle.
- Handshake:
  - advance = !out_valid || out_ready; in_ready = advance.
  - accept when in_valid && in_ready.
  - When advance=1, every stage shifts forward and empty slots propagate as bubbles (valid=0).
  - When advance=0, all stage registers hold. out_data and out_tag are stable while out_valid && !out_ready.
- Simultaneous events:
  - Accept and retire in the same cycle is allowed at full rate.
  - Input is ignored while in_ready=0; the source must hold its values.
- No ordering hazards: results emerge in acceptance order.
- Reset mid-operation: all in-flight ops are discarded and no out_valid pulse appears after release.
- Out-of-range amounts cannot occur: in_amt is SHW bits wide, so it is always < WIDTH.

Optional Feature:
- BSH_FLAGS_EN defined:
  - adds outputs out_zero (1 bit; out_data == 0) and out_carry (1 bit).
  - out_carry is the last bit shifted or rotated out: in[n-1] for ROR/SRL/SRA, in[WIDTH-n] for ROL, and 0 when n=0.
  - Both are registered and aligned with out_data, and both reset to 0.
- BSH_FLAGS_EN undefined: these ports and their logic are absent.

Decomposition:
- Package bsh_pkg holds:
  - typedef enum logic [1:0] bsh_op_t {BSH_ROR, BSH_ROL, BSH_SRL, BSH_SRA}.
  - function bsh_stage_cnt(width) returning $clog2(width).
- Sub-module bsh_stage:
  - parameters WIDTH, STEP (= 2^k), TAG_W.
  - performs one conditional shift plus its pipeline register with hold enable.
- The top module generates SHW instances of bsh_stage and the handshake logic.

Test Plan:
- WIDTH=32, no stall: ROR 0x12345678 amt 4 -> 0x81234567; ROL 0x12345678 amt 8 -> 0x34567812; each appears exactly 5 cycles after accept, tags preserved.
- SRL 0x80000000 amt 31 -> 0x00000001; SRA 0xF0000000 amt 4 -> 0xFF000000; SRA 0x70000000 amt 4 -> 0x07000000.
- Back-to-back stream of 8 ops with tags 0..7 and out_ready held low cycles 3-6: no op lost or duplicated, order preserved, out_data stable while stalled, in_ready=0 during the stall.
- amt=0 for all four ops on 0xDEADBEEF -> 0xDEADBEEF. WIDTH=4 build: ROR 4'b1000 amt 1 -> 4'b0100, latency 2.
- Assert rst_n low with 3 ops in flight: out_valid drops immediately, and no result emerges after release.
- BSH_FLAGS_EN: SRL 0x00000003 amt 2 -> out_data 0, out_zero=1, out_carry=1; ROR any value amt 0 -> out_carry=0.

Source files
------------

// File: rtl/bsh_pkg.sv
// Shared types and helpers for the pipelined barrel shifter.
package bsh_pkg;

  typedef enum logic [1:0] {
    BSH_ROR = 2'd0,
    BSH_ROL = 2'd1,
    BSH_SRL = 2'd2,
    BSH_SRA = 2'd3
  } bsh_op_t;

  // One pipeline stage per shift-amount bit.
  function automatic int unsigned bsh_stage_cnt(input int unsigned width);
    return unsigned'($clog2(width));
  endfunction

endpackage

// File: rtl/bsh_stage.sv
// One pipeline stage of the barrel shifter: conditional shift by STEP plus its register.
// Optional flags (carry/zero) are built when BSH_FLAGS_EN is defined.
module bsh_stage
  import bsh_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned STEP  = 1,
  parameter int unsigned TAG_W = 4,
  localparam int unsigned SHW  = bsh_stage_cnt(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] word_i,
  input  logic [SHW-1:0]   amt_i,
  input  bsh_op_t          op_i,
  input  logic [TAG_W-1:0] tag_i,
  input  logic             sign_i,
`ifdef BSH_FLAGS_EN
  input  logic             carry_i,
  output logic             carry_o,
  output logic             zero_o,
`endif
  output logic             valid_o,
  output logic [WIDTH-1:0] word_o,
  output logic [SHW-1:0]   amt_o,
  output bsh_op_t          op_o,
  output logic [TAG_W-1:0] tag_o,
  output logic             sign_o
);

  // Amount bit that selects this stage's shift.
  localparam int unsigned AmtBit = unsigned'($clog2(STEP));

  logic [WIDTH-1:0] shifted;
  logic             carry_nxt;

  // Conditional shift by STEP; the carry tracks the last bit pushed out so far.
  always_comb begin
    shifted   = word_i;
    carry_nxt = 1'b0;
`ifdef BSH_FLAGS_EN
    carry_nxt = carry_i;
`endif
    if (amt_i[AmtBit]) begin
      unique case (op_i)
        BSH_ROR: shifted = (word_i >> STEP) | (word_i << (WIDTH - STEP));
        BSH_ROL: shifted = (word_i << STEP) | (word_i >> (WIDTH - STEP));
        BSH_SRL: shifted = word_i >> STEP;
        BSH_SRA: shifted = (word_i >> STEP) | (sign_i ? ~({WIDTH{1'b1}} >> STEP) : '0);
      endcase
      carry_nxt = (op_i == BSH_ROL) ? word_i[WIDTH-STEP] : word_i[STEP-1];
    end
  end

  // Stage register; holds everything while the pipe is stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_o <= 1'b0;
      word_o  <= '0;
      amt_o   <= '0;
      op_o    <= BSH_ROR;
      tag_o   <= '0;
      sign_o  <= 1'b0;
`ifdef BSH_FLAGS_EN
      carry_o <= 1'b0;
      zero_o  <= 1'b0;
`endif
    end else if (en_i) begin
      valid_o <= valid_i;
      word_o  <= shifted;
      amt_o   <= amt_i;
      op_o    <= op_i;
      tag_o   <= tag_i;
      sign_o  <= sign_i;
`ifdef BSH_FLAGS_EN
      carry_o <= carry_nxt;
      zero_o  <= (shifted == '0);
`endif
    end
  end

`ifndef BSH_FLAGS_EN
  logic unused_carry;
  assign unused_carry = carry_nxt;
`endif

endmodule

// File: rtl/barrel_shift_pipe.sv
// Pipelined barrel shifter (ROR/ROL/SRL/SRA) with valid/ready on both sides.
// Define BSH_FLAGS_EN to add the out_zero/out_carry result flags.
module barrel_shift_pipe
  import bsh_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned TAG_W = 4,
  localparam int unsigned SHW  = bsh_stage_cnt(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_amt,
  input  logic [1:0]       in_op,
  input  logic [TAG_W-1:0] in_tag,
`ifdef BSH_FLAGS_EN
  output logic             out_zero,
  output logic             out_carry,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [TAG_W-1:0] out_tag
);

  // Index 0 is the combinational input; index k+1 is the register of stage k.
  logic [SHW:0]             valid;
  logic [SHW:0][WIDTH-1:0]  word;
  logic [SHW:0][SHW-1:0]    amt;
  bsh_op_t                  op [SHW+1];
  logic [SHW:0][TAG_W-1:0]  tag;
  logic [SHW:0]             sign;
  logic                     advance;

  // Whole pipe moves together; it only stalls when the output slot is full and blocked.
  assign advance  = !valid[SHW] || out_ready;
  assign in_ready = advance;

  assign valid[0] = in_valid;
  assign word[0]  = in_data;
  assign amt[0]   = in_amt;
  assign op[0]    = bsh_op_t'(in_op);
  assign tag[0]   = in_tag;
  assign sign[0]  = in_data[WIDTH-1];

`ifdef BSH_FLAGS_EN
  logic [SHW:0]   carry;
  logic [SHW-1:0] zero;
  assign carry[0] = 1'b0;
`endif

  for (genvar k = 0; k < SHW; k++) begin : g_stage
    bsh_stage #(
      .WIDTH (WIDTH),
      .STEP  (1 << k),
      .TAG_W (TAG_W)
    ) u_stage (
      .clk     (clk),
      .rst_n   (rst_n),
      .en_i    (advance),
      .valid_i (valid[k]),
      .word_i  (word[k]),
      .amt_i   (amt[k]),
      .op_i    (op[k]),
      .tag_i   (tag[k]),
      .sign_i  (sign[k]),
`ifdef BSH_FLAGS_EN
      .carry_i (carry[k]),
      .carry_o (carry[k+1]),
      .zero_o  (zero[k]),
`endif
      .valid_o (valid[k+1]),
      .word_o  (word[k+1]),
      .amt_o   (amt[k+1]),
      .op_o    (op[k+1]),
      .tag_o   (tag[k+1]),
      .sign_o  (sign[k+1])
    );
  end

  assign out_valid = valid[SHW];
  assign out_data  = word[SHW];
  assign out_tag   = tag[SHW];

`ifdef BSH_FLAGS_EN
  assign out_carry = carry[SHW];
  assign out_zero  = zero[SHW-1];
  logic unused_zero;
  assign unused_zero = ^zero[SHW-2:0];
`endif

  // Control fields of the last stage have no consumer.
  logic unused_tail;
  assign unused_tail = ^{amt[SHW], sign[SHW], op[SHW]};

endmodule
